// File: rtl/lc3b_writeback_buffer.sv
// Dirty-line eviction buffer between the L1 data cache and the next memory level.
// Retires lines in FIFO order, coalesces repeat evictions and serves refill lookups.
module lc3b_writeback_buffer #(
  parameter int LINE_W  = 128,
  parameter int TAG_W   = 9,
  parameter int INDEX_W = 3,
  parameter int DEPTH   = 4
) (
  input  logic                       clk,
  input  logic                       rst,
  input  logic                       wb_write,
  input  logic [TAG_W+INDEX_W-1:0]   wb_addr,
  input  logic [LINE_W-1:0]          wb_wdata,
  output logic                       wb_full,
  input  logic                       lk_req,
  input  logic [TAG_W+INDEX_W-1:0]   lk_addr,
  output logic                       lk_hit,
  output logic [LINE_W-1:0]          lk_rdata,
  output logic                       mem_write,
  output logic [TAG_W+INDEX_W-1:0]   mem_addr,
  output logic [LINE_W-1:0]          mem_wdata,
  input  logic                       mem_resp,
  output logic                       wb_empty
);

  localparam int LA_W  = TAG_W + INDEX_W;
  localparam int PTR_W = $clog2(DEPTH);
  localparam int CNT_W = PTR_W + 1;
  localparam logic [CNT_W-1:0] FULL_CNT = CNT_W'(DEPTH);

  logic [DEPTH-1:0]  r_valid;
  logic [LA_W-1:0]   r_addr [DEPTH];
  logic [LINE_W-1:0] r_data [DEPTH];
  logic [PTR_W-1:0]  r_head;
  logic [PTR_W-1:0]  r_tail;
  logic [CNT_W-1:0]  r_count;

  logic              w_empty;
  logic              w_full;
  logic              w_pop;
  logic              w_alloc;
  logic [DEPTH-1:0]  w_not_head;
  logic              w_co_hit;
  logic [PTR_W-1:0]  w_co_idx;
  logic              w_lk_nh_hit;
  logic [PTR_W-1:0]  w_lk_nh_idx;
  logic              w_lk_hd_hit;

  assign w_empty = (r_count == '0);
  assign w_full  = (r_count == FULL_CNT);
  assign w_pop   = !w_empty && mem_resp;
  // Fullness is judged on the pre-edge count; a same-edge pop does not make room.
  assign w_alloc = wb_write && !w_co_hit && !w_full;

  always_comb begin
    w_not_head = '0;
    for (int i = 0; i < DEPTH; i++) begin
      w_not_head[i] = (PTR_W'(i) != r_head);
    end
  end

  // The head may be mid-transfer, so it is never a coalescing target.
  always_comb begin
    w_co_hit = 1'b0;
    w_co_idx = '0;
    for (int i = 0; i < DEPTH; i++) begin
      if (r_valid[i] && w_not_head[i] && (r_addr[i] == wb_addr)) begin
        w_co_hit = 1'b1;
        w_co_idx = PTR_W'(i);
      end
    end
  end

  always_comb begin
    w_lk_nh_hit = 1'b0;
    w_lk_nh_idx = '0;
    for (int i = 0; i < DEPTH; i++) begin
      if (r_valid[i] && w_not_head[i] && (r_addr[i] == lk_addr)) begin
        w_lk_nh_hit = 1'b1;
        w_lk_nh_idx = PTR_W'(i);
      end
    end
  end

  assign w_lk_hd_hit = r_valid[r_head] && (r_addr[r_head] == lk_addr);

  // A non-head match always holds younger data than a head match.
  always_comb begin
    lk_hit   = 1'b0;
    lk_rdata = '0;
    if (lk_req) begin
      if (w_lk_nh_hit) begin
        lk_hit   = 1'b1;
        lk_rdata = r_data[w_lk_nh_idx];
      end else if (w_lk_hd_hit) begin
        lk_hit   = 1'b1;
        lk_rdata = r_data[r_head];
      end
    end
  end

  assign mem_write = !w_empty;
  assign mem_addr  = w_empty ? '0 : r_addr[r_head];
  assign mem_wdata = w_empty ? '0 : r_data[r_head];
  assign wb_full   = w_full;
  assign wb_empty  = w_empty;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_valid <= '0;
      r_head  <= '0;
      r_tail  <= '0;
      r_count <= '0;
    end else begin
      if (w_pop) begin
        r_valid[r_head] <= 1'b0;
        r_head          <= r_head + PTR_W'(1);
      end
      if (w_alloc) begin
        r_valid[r_tail] <= 1'b1;
        r_tail          <= r_tail + PTR_W'(1);
      end
      r_count <= r_count + CNT_W'(w_alloc) - CNT_W'(w_pop);
    end
  end

  // Line storage carries no reset; every read of it is qualified by a valid bit or the count.
  always_ff @(posedge clk) begin
    if (wb_write && w_co_hit) begin
      r_data[w_co_idx] <= wb_wdata;
    end else if (w_alloc) begin
      r_addr[r_tail] <= wb_addr;
      r_data[r_tail] <= wb_wdata;
    end
  end

endmodule

// File: doc/lc3b_writeback_buffer.md
Name: lc3b_writeback_buffer

Overview:
- Parametrised dirty-line eviction buffer between the L1 data cache and the next memory level.
- Accepts evicted lines from the L1 and retires them to memory in FIFO order over a request/response handshake.
- Coalesces repeat evictions of the same line.
- Serves same-cycle lookups so an L1 miss can be refilled from a pending eviction.
- Generalises the fixed 128-bit line / 9-bit tag / 3-bit index cache geometry to arbitrary widths and buffer depth.

Parameters:
- LINE_W, 128, cache line width in bits.
- TAG_W, 9, tag width in bits.
- INDEX_W, 3, set index width in bits. Line address width LA_W = TAG_W + INDEX_W.
- DEPTH, 4, number of buffer entries; power of two, >= 2.

Ports:
- clk  in  1  clock; all state updates on the rising edge.
- rst  in  1  reset, asynchronous, active-high.
- wb_write  in  1  enqueue request from the L1 eviction path.
- wb_addr  in  LA_W  line address {tag,index} of the evicted line.
- wb_wdata  in  LINE_W  evicted line data.
- wb_full  out  1  high when count == DEPTH.
- lk_req  in  1  lookup request from the L1 miss path.
- lk_addr  in  LA_W  lookup line address.
- lk_hit  out  1  lookup matched a valid entry; combinational.
- lk_rdata  out  LINE_W  data of the matched entry; 0 when no hit.
- mem_write  out  1  write request to memory.
- mem_addr  out  LA_W  head entry line address.
- mem_wdata  out  LINE_W  head entry data.
- mem_resp  in  1  memory write complete.
- wb_empty  out  1  high when count == 0.

Behaviour:
- Storage: DEPTH entries of {valid, addr, data}; head and tail pointers of log2(DEPTH) bits, wrapping modulo DEPTH; count of log2(DEPTH)+1 bits.
- Reset (asynchronous, takes effect immediately, including mid-drain):
  - count, head, tail cleared to 0; all valid bits cleared.
  - mem_write=0, mem_addr=0, mem_wdata=0, wb_full=0, wb_empty=1, lk_hit=0, lk_rdata=0.
  - An in-flight memory write is abandoned; the memory side must tolerate a dropped request.
- Drain:
  - mem_write = (count != 0). mem_addr and mem_wdata come from the head entry, or 0 when empty.
  - These outputs are held stable until mem_resp.
  - On a clock edge with mem_resp=1 and mem_write=1: invalidate the head entry, head++ with wrap, count--.
  - mem_resp while empty is ignored.
- Enqueue (on a clock edge with wb_write=1):
  - Coalesce match: a valid non-head entry whose addr == wb_addr. Overwrite its data in place; count and tail are unchanged.
  - The head is never coalesced, because it may be mid-transfer. A write to the head's address allocates a new entry.
  - At most one non-head match can exist; coalescing guarantees this.
  - No match and count < DEPTH: write the entry at tail, set valid, tail++ with wrap.
  - No match and count == DEPTH: the write is dropped and state is unchanged. This is a protocol violation, checked by a bench assertion.
  - A coalescing write is accepted even when wb_full=1.
- Simultaneous enqueue and pop in one edge:
  - Both take effect; net count is unchanged if the enqueue allocated.
  - Fullness uses the pre-edge count. There is no bypass: a push at full without a coalesce match is dropped even if mem_resp pops in the same edge.
  - The coalesce check uses pre-edge contents, excluding the pre-edge head.
- Lookup:
  - Combinational over pre-edge contents when lk_req=1.
  - If a non-head match exists, return it (youngest data); otherwise return a head match if present.
  - A write in the same cycle is not forwarded to lookup.
  - lk_req=0 forces lk_hit=0 and lk_rdata=0.
- Status outputs: wb_full and wb_empty decode directly from the registered count, with no extra latency.
- Latency:
  - An enqueued line is visible to lookup and memory one cycle after the accepting edge.
  - Minimum residency is 1 cycle, when mem_resp is returned immediately.

Test Plan:
- Reset then idle -> wb_empty=1, mem_write=0, lk_hit=0 for lk_addr=12'h0A3.
- Enqueue 12'h101 with data A, then 12'h202 with data B, mem_resp held low -> mem_write=1, mem_addr=12'h101, mem_wdata=A. After one mem_resp pulse: mem_addr=12'h202, count=1.
- Coalescing:
  - Enqueue 12'h101/A, 12'h202/B, 12'h202/C -> count=2; lookup 12'h202 gives lk_hit=1, lk_rdata=C.
  - Enqueue 12'h101/D while 101 is at the head -> count=3; lookup 12'h101 returns D.
- DEPTH=4: fill with 4 distinct addresses -> wb_full=1. A 5th distinct write with mem_resp high in the same edge is dropped: count=3 afterwards, dropped address misses lookup. A coalescing write at full is accepted.
- Wrap-around: 10 enqueue/drain cycles with alternating mem_resp -> addresses retire in exact enqueue order; pointers wrap with no lost or duplicated line.
- Assert rst asynchronously mid-cycle while mem_write=1 with 3 entries -> mem_write drops before the next clk edge, wb_empty=1, and subsequent lookups miss.
